// File: rtl/uart_frame_transmitter_if.sv
// Producer-side handshake bundle for uart_frame_transmitter.
// The master (producer) drives the byte and valid; the slave returns ready.
interface uart_frame_transmitter_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_frame_transmitter.sv
// Configurable UART transmitter with a one-entry holding register.
// Optional break generation is enabled by defining UART_TX_BREAK_EN.
module uart_frame_transmitter #(
  parameter int unsigned INTERNAL_CLOCK = 125000000,
  parameter int unsigned DATA_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] config_register,
  uart_frame_transmitter_if.slave bus,
`ifdef UART_TX_BREAK_EN
  input  logic                  send_break,
`endif
  output logic                  TX,
  output logic                  tx_busy,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = $clog2(INTERNAL_CLOCK / 9600 + 1);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`endif

  function automatic logic [CNT_W-1:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'd0:    return CNT_W'(INTERNAL_CLOCK / 9600);
      3'd1:    return CNT_W'(INTERNAL_CLOCK / 19200);
      3'd2:    return CNT_W'(INTERNAL_CLOCK / 38400);
      3'd3:    return CNT_W'(INTERNAL_CLOCK / 57600);
      3'd4:    return CNT_W'(INTERNAL_CLOCK / 115200);
      3'd5:    return CNT_W'(INTERNAL_CLOCK / 230400);
      3'd6:    return CNT_W'(INTERNAL_CLOCK / 460800);
      default: return CNT_W'(INTERNAL_CLOCK / 921600);
    endcase
  endfunction

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_div;
  logic [3:0]            r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par;
  logic                  r_par_en;
  logic                  r_stop2;
  logic [2:0]            r_nbits_m1;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_frame_done;

  logic                  w_bit_end;
  logic                  w_data_last;
  logic                  w_stop_last;
  logic                  w_hs;
  logic                  w_frame_start;
  logic                  w_cfg_load;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_masked;

  assign w_bit_end     = (r_state != S_IDLE) && (r_cnt == r_div - CNT_W'(1));
  assign w_data_last   = (r_bit_idx == {1'b0, r_nbits_m1});
  assign w_stop_last   = (r_bit_idx[0] == r_stop2);
  assign w_hs          = bus.data_valid && !r_hold_full;
  assign w_frame_start = (w_next == S_START) && (r_state != S_START);
  assign w_cfg_load    = ((r_state == S_IDLE) && (w_next != S_IDLE)) || w_frame_start;
  assign w_masked      = r_hold_data & w_mask;

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++)
      w_mask[i] = (i < 5 + int'(config_register[1:0]));
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (send_break)       w_next = S_BREAK;
        else if (r_hold_full) w_next = S_START;
`else
        if (r_hold_full)      w_next = S_START;
`endif
      end
      S_START:  if (w_bit_end) w_next = S_DATA;
      S_DATA:   if (w_bit_end && w_data_last) w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_next = S_STOP;
      S_STOP:   if (w_bit_end && w_stop_last) w_next = r_hold_full ? S_START : S_IDLE;
`ifdef UART_TX_BREAK_EN
      // Leave on the 13th period boundary at the earliest, or later once send_break drops.
      S_BREAK:  if (!send_break && ((r_bit_idx == 4'd13) || (r_bit_idx == 4'd12 && w_bit_end)))
                  w_next = S_MARK;
      S_MARK:   if (w_bit_end) w_next = S_IDLE;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    TX             = 1'b1;
    tx_busy        = (r_state != S_IDLE);
    frame_done     = r_frame_done;
    bus.data_ready = !r_hold_full;
    case (r_state)
      S_START:  TX = 1'b0;
      S_DATA:   TX = r_shift[0];
      S_PARITY: TX = r_par;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  TX = 1'b0;
`endif
      default:  TX = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_div        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_par_en     <= 1'b0;
      r_stop2      <= 1'b0;
      r_nbits_m1   <= '0;
      r_hold_full  <= 1'b0;
      r_hold_data  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == S_STOP) && w_bit_end && w_stop_last;

      if ((w_next != r_state) || w_bit_end) r_cnt <= '0;
      else                                  r_cnt <= r_cnt + CNT_W'(1);

      if (w_next != r_state)                        r_bit_idx <= '0;
      else if (w_bit_end && (r_bit_idx != 4'd13))   r_bit_idx <= r_bit_idx + 4'd1;

      if (w_cfg_load) begin
        r_div      <= baud_div(config_register[7:5]);
        r_stop2    <= config_register[4];
        r_par_en   <= config_register[3] ^ config_register[2];
        r_nbits_m1 <= {1'b1, config_register[1:0]};
        r_shift    <= w_masked;
        r_par      <= (^w_masked) ^ config_register[2];
      end else if ((r_state == S_DATA) && w_bit_end) begin
        r_shift    <= r_shift >> 1;
      end

      // Holding register is full whenever a drain could happen, so drain and refill never collide.
      if (w_frame_start) begin
        r_hold_full <= 1'b0;
      end else if (w_hs) begin
        r_hold_full <= 1'b1;
        r_hold_data <= bus.data_in;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_transmitter.sv
// Directed self-checking bench for uart_frame_transmitter at 1.152 MHz (DIV=10 at 115200).
// Break sequence is exercised only when UART_TX_BREAK_EN is defined.
module tb_uart_frame_transmitter;
  localparam int unsigned CLK_HZ = 1152000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg;
  logic       tx;
  logic       busy;
  logic       done;
`ifdef UART_TX_BREAK_EN
  logic       brk;
`endif

  uart_frame_transmitter_if #(.DATA_WIDTH(8)) bus_if ();

  uart_frame_transmitter #(
    .INTERNAL_CLOCK(CLK_HZ),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .config_register(cfg),
    .bus(bus_if),
`ifdef UART_TX_BREAK_EN
    .send_break(brk),
`endif
    .TX(tx),
    .tx_busy(busy),
    .frame_done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    @(negedge clk);
    bus_if.data_in    = d;
    bus_if.data_valid = 1'b1;
    n = 0;
    while (!bus_if.data_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.data_ready) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1 bus_if.data_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  cfg;
    logic [7:0]  data;
    int          div;
    int          len;
    logic [11:0] bits;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          werr, busyc, donec, donepos, hsc, idx, doneerr, busyerr, cnt;
    logic        exp_tx, hs;
    logic [7:0]  seq [3];
    logic [11:0] fbits [3];
    logic [11:0] a5_bits, c3_bits;

    // {config, data, DIV, frame length in bits, expected TX per bit period (bit0 = start)}
    vecs[0] = '{8'h83, 8'hA5, 10, 10, 12'h34A};
    vecs[1] = '{8'h9A, 8'h53, 10, 11, 12'h6A6};
    vecs[2] = '{8'h80, 8'hF3, 10,  7, 12'h066};
    vecs[3] = '{8'h8D, 8'h2A, 10,  8, 12'h0D4};
    vecs[4] = '{8'hA5, 8'h07,  5,  9, 12'h10E};
    vecs[5] = '{8'h96, 8'h01, 10, 11, 12'h602};

    rst = 1'b1;
    cfg = 8'h83;
    bus_if.data_in    = '0;
    bus_if.data_valid = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_ready", int'(bus_if.data_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      cfg = vecs[v].cfg;
      send_byte(vecs[v].data);
      werr = 0; busyc = 0; donec = 0; donepos = -1;
      for (int c = 0; c <= vecs[v].len * vecs[v].div + 2; c++) begin
        @(negedge clk);
        if (c >= 1 && c <= vecs[v].len * vecs[v].div) exp_tx = vecs[v].bits[(c - 1) / vecs[v].div];
        else                                          exp_tx = 1'b1;
        if (tx !== exp_tx) werr++;
        if (busy) busyc++;
        if (done) begin donec++; donepos = c; end
      end
      check($sformatf("v%0d_wave_errors", v), werr, 0);
      check($sformatf("v%0d_busy_cycles", v), busyc, vecs[v].len * vecs[v].div);
      check($sformatf("v%0d_done_count", v), donec, 1);
      check($sformatf("v%0d_done_cycle", v), donepos, vecs[v].len * vecs[v].div + 1);
    end

    // Back-to-back odd-parity frames with data_valid held high
    cfg = 8'h87;
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
    fbits[0] = 12'h600; fbits[1] = 12'h7FE; fbits[2] = 12'h678;
    @(posedge clk);
    #1;
    bus_if.data_in = seq[0];
    bus_if.data_valid = 1'b1;
    idx = 0; werr = 0; hsc = 0; doneerr = 0; donec = 0; busyerr = 0;
    for (int c = 0; c <= 336; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 331) exp_tx = fbits[(c - 2) / 110][((c - 2) % 110) / 10];
      else                    exp_tx = 1'b1;
      if (tx !== exp_tx) werr++;
      if (busy !== (c >= 2 && c <= 331)) busyerr++;
      if (done) begin
        donec++;
        if (c != 112 && c != 222 && c != 332) doneerr++;
      end
      hs = bus_if.data_valid && bus_if.data_ready;
      if (hs) hsc++;
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        if (idx < 3) bus_if.data_in = seq[idx];
        else         bus_if.data_valid = 1'b0;
      end
    end
    check("b2b_wave_errors", werr, 0);
    check("b2b_busy_errors", busyerr, 0);
    check("b2b_handshakes", hsc, 3);
    check("b2b_done_count", donec, 3);
    check("b2b_done_misplaced", doneerr, 0);

    // Mid-frame reset with a byte queued in the holding register
    cfg = 8'h83;
    send_byte(8'hA5);
    for (int c = 0; c <= 45; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus_if.data_in = 8'h3C;
        bus_if.data_valid = 1'b1;
      end
      if (c == 2) begin
        check("rst_hold_full_ready", int'(bus_if.data_ready), 0);
        bus_if.data_valid = 1'b0;
      end
      if (c == 45) begin
        check("rst_data_bit3_tx", int'(tx), 0);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    check("rst_after_tx", int'(tx), 1);
    check("rst_after_ready", int'(bus_if.data_ready), 1);
    check("rst_after_busy", int'(busy), 0);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!tx || busy || done) cnt++;
    end
    check("rst_queued_not_sent", cnt, 0);

    // Config change mid-frame: next frame picks up DIV=5
    cfg = 8'h83;
    a5_bits = 12'h34A;
    c3_bits = 12'h278;
    send_byte(8'hA5);
    werr = 0; doneerr = 0; donec = 0;
    for (int c = 0; c <= 155; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus_if.data_in = 8'h3C;
        bus_if.data_valid = 1'b1;
      end
      if (c == 2) bus_if.data_valid = 1'b0;
      if (c == 50) cfg = 8'hA3;
      if (c >= 1 && c <= 100)        exp_tx = a5_bits[(c - 1) / 10];
      else if (c >= 101 && c <= 150) exp_tx = c3_bits[(c - 101) / 5];
      else                           exp_tx = 1'b1;
      if (tx !== exp_tx) werr++;
      if (done) begin
        donec++;
        if (c != 101 && c != 151) doneerr++;
      end
    end
    check("cfg_wave_errors", werr, 0);
    check("cfg_done_count", donec, 2);
    check("cfg_done_misplaced", doneerr, 0);

`ifdef UART_TX_BREAK_EN
    cfg = 8'h83;
    @(negedge clk);
    brk = 1'b1;
    werr = 0; busyerr = 0;
    for (int c = 0; c <= 145; c++) begin
      @(negedge clk);
      if (c == 1) brk = 1'b0;
      if (tx !== (c >= 130)) werr++;
      if (busy !== (c < 140)) busyerr++;
    end
    check("brk_wave_errors", werr, 0);
    check("brk_busy_errors", busyerr, 0);
    check("brk_ready", int'(bus_if.data_ready), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
